// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS timer/counter blocks: FSM encodings and default width.
package mips_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } cd_state_t;

endpackage : mips_pkg

// File: rtl/dec_by1.sv
// dec_by1: combinational subtract-one (o_y = i_a - 1, modulo 2^WIDTH).
// Ports:
//   i_a  in  WIDTH  operand
//   o_y  out WIDTH  i_a - 1
// Borrow lookahead: bit i flips exactly when every lower bit is zero.
module dec_by1
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    output logic [WIDTH-1:0] o_y
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == 0) begin : g_lsb
            assign o_y[0] = ~i_a[0];
        end else begin : g_upper
            assign o_y[i] = i_a[i] ^ ~(|i_a[i-1:0]);
        end
    end

endmodule : dec_by1

// File: rtl/countdown32.sv
// countdown32: loadable down-counter with start/pause, one-cycle done pulse
// and sticky irq. Optional auto-reload restarts from the last loaded value.
// Ports:
//   clk       in  1      rising-edge clock
//   rst       in  1      asynchronous reset, active-high
//   load      in  1      capture load_val into count and reload register
//   load_val  in  WIDTH  value to load
//   start     in  1      begin counting (IDLE only)
//   pause     in  1      hold count (RUN only)
//   irq_clr   in  1      clear irq (a coincident set wins)
//   count     out WIDTH  current counter value
//   busy      out 1      high while in RUN
//   done      out 1      one-cycle expiry pulse
//   irq       out 1      sticky expiry flag
module countdown32
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH       = DEFAULT_WIDTH,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             irq_clr,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             irq
);

    cd_state_t        r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_busy;
    logic             r_done;
    logic             r_irq;

    logic [WIDTH-1:0] w_dec;
    logic [WIDTH-1:0] w_eff;
    logic [WIDTH-1:0] w_rel;

    dec_by1 #(.WIDTH(WIDTH)) u_dec (
        .i_a (r_count),
        .o_y (w_dec)
    );

    // Value seen by start in IDLE, and value restarted from in DONE;
    // a same-cycle load takes precedence over the stored value.
    assign w_eff = load ? load_val : r_count;
    assign w_rel = load ? load_val : r_reload;

    // FSM with registered count, reload, busy, done and irq.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_irq  <= r_irq & ~irq_clr;
            if (load) begin
                r_reload <= load_val;
            end

            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        r_count <= load_val;
                    end
                    if (start) begin
                        if (w_eff == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_irq   <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    // Restart has priority over pause and decrement.
                    if (load) begin
                        r_count <= load_val;
                        if (load_val == '0) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_irq   <= 1'b1;
                        end
                    end else if (!pause) begin
                        r_count <= w_dec;
                        if (r_count == WIDTH'(1)) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_irq   <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    if (AUTO_RELOAD && (w_rel != '0)) begin
                        r_count <= w_rel;
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end else begin
                        if (load) begin
                            r_count <= load_val;
                        end
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign count = r_count;
    assign busy  = r_busy;
    assign done  = r_done;
    assign irq   = r_irq;

endmodule : countdown32
